// File: rtl/reg_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : reg_share_arb
// Brief    : Round-robin arbiter and write/readback sequencer for one shared
//            enable-register.
// Revision : 1.0 - initial release
// ============================================================================
module reg_share_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0]      reg_out,
    output logic                  reg_en,
    output logic [WIDTH-1:0]      reg_in,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic                  err_sticky,
    output logic [IDW-1:0]        owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              mis_q, mis_d;
    logic              reg_en_q, reg_en_d;
    logic [WIDTH-1:0]  reg_in_q, reg_in_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic              sticky_q, sticky_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [IDW-1:0]    win_idx;

    // Search from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        mis_d    = mis_q;
        reg_en_d = 1'b0;
        reg_in_d = reg_in_q;
        ack_d    = '0;
        err_d    = 1'b0;
        sticky_d = sticky_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    owner_d  = win_idx;
                    data_d   = wr_data[win_idx*WIDTH +: WIDTH];
                    reg_en_d = 1'b1;
                    reg_in_d = wr_data[win_idx*WIDTH +: WIDTH];
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                // Outputs are registered, so the ack-cycle values are formed here.
                mis_d    = (reg_out != data_q);
                ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                err_d    = mis_d;
                sticky_d = sticky_q | mis_d;
                state_d  = ACK;
            end
            ACK: begin
                ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                mis_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            data_q   <= '0;
            mis_q    <= 1'b0;
            reg_en_q <= 1'b0;
            reg_in_q <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            mis_q    <= mis_d;
            reg_en_q <= reg_en_d;
            reg_in_q <= reg_in_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            busy_q   <= busy_d;
        end
    end

    assign reg_en     = reg_en_q;
    assign reg_in     = reg_in_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign owner      = owner_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_share_arb
// Brief    : Directed self-checking bench for reg_share_arb with a reg8 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_share_arb;

    logic        clk;
    logic        res;
    logic [3:0]  req;
    logic [31:0] wr_data;
    logic [7:0]  reg_out;
    logic        reg_en;
    logic [7:0]  reg_in;
    logic [3:0]  ack;
    logic        err;
    logic        err_sticky;
    logic [1:0]  owner;
    logic        busy;

    logic [7:0]  reg_model;
    logic        force_bad;
    int          cyc;
    int          checks;
    int          failures;

    reg_share_arb #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
        .clk        (clk),
        .res        (res),
        .req        (req),
        .wr_data    (wr_data),
        .reg_out    (reg_out),
        .reg_en     (reg_en),
        .reg_in     (reg_in),
        .ack        (ack),
        .err        (err),
        .err_sticky (err_sticky),
        .owner      (owner),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared reg8 stand-in; force_bad corrupts its readback.
    always @(posedge clk or negedge res) begin
        if (!res) reg_model <= 8'h00;
        else if (reg_en) reg_model <= reg_in;
    end
    assign reg_out = force_bad ? 8'h00 : reg_model;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (reg_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 res = 1'b0;
        #2 res = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if ({reg_en, reg_in, ack, err, err_sticky, owner, busy} !== 17'h0) begin
            failures++; $display("FAIL reset_outputs got=%0h exp=0", {reg_en, reg_in, ack, err, err_sticky, owner, busy});
        end
        #4 res = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if ({reg_en, ack, busy} !== 6'h0) begin
                failures++; $display("FAIL idle_quiet cyc=%0d got=%0h exp=0", i, {reg_en, ack, busy});
            end
        end
    endtask

    task automatic test_single();
        wr_data = 32'h0000_0077;
        req     = 4'b0001;
        @(negedge clk);
        checks++; if ({reg_en, reg_in, owner, busy} !== {1'b1, 8'h77, 2'd0, 1'b1}) begin
            failures++; $display("FAIL single_write got=%0h exp=%0h", {reg_en, reg_in, owner, busy}, {1'b1, 8'h77, 2'd0, 1'b1});
        end
        @(negedge clk);
        checks++; if ({reg_en, reg_out, ack} !== {1'b0, 8'h77, 4'h0}) begin
            failures++; $display("FAIL single_verify got=%0h exp=%0h", {reg_en, reg_out, ack}, {1'b0, 8'h77, 4'h0});
        end
        @(negedge clk);
        checks++; if ({ack, err, owner} !== {4'b0001, 1'b0, 2'd0}) begin
            failures++; $display("FAIL single_ack got=%0h exp=%0h", {ack, err, owner}, {4'b0001, 1'b0, 2'd0});
        end
        req = 4'b0000;
        @(negedge clk);
        checks++; if ({busy, ack, reg_en, reg_in} !== {1'b0, 4'h0, 1'b0, 8'h77}) begin
            failures++; $display("FAIL single_idle got=%0h exp=%0h", {busy, ack, reg_en, reg_in}, {1'b0, 4'h0, 1'b0, 8'h77});
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int last;
        logic [7:0] exp_d;
        reset_pulse();
        wr_data = 32'h4433_2211;
        req     = 4'b1111;
        last    = -1;
        for (int g = 0; g < 4; g++) begin
            exp_d = 8'(8'h11 * (g + 1));
            wait_grant(ok);
            checks++; if (!ok) begin
                failures++; $display("FAIL fair_timeout grant=%0d got=none exp=grant", g);
                return;
            end
            checks++; if ({owner, reg_in} !== {2'(g), exp_d}) begin
                failures++; $display("FAIL fair_grant g=%0d got=%0h exp=%0h", g, {owner, reg_in}, {2'(g), exp_d});
            end
            if (last >= 0) begin
                checks++; if (cyc - last !== 4) begin
                    failures++; $display("FAIL fair_spacing g=%0d got=%0d exp=4", g, cyc - last);
                end
            end
            last = cyc;
            @(negedge clk);
            @(negedge clk);
            checks++; if (ack !== 4'(1 << g)) begin
                failures++; $display("FAIL fair_ack g=%0d got=%b exp=%b", g, ack, 4'(1 << g));
            end
            req[g] = 1'b0;
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [1:0] exp_o [2];
        exp_o[0] = 2'd0;
        exp_o[1] = 2'd3;
        wr_data = 32'hA300_00A0;
        req     = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            wait_grant(ok);
            checks++; if (!ok) begin
                failures++; $display("FAIL wrap_timeout k=%0d got=none exp=grant", k);
                return;
            end
            checks++; if ({owner, reg_in} !== {exp_o[k], (k == 0) ? 8'hA0 : 8'hA3}) begin
                failures++; $display("FAIL wrap_order k=%0d got=%0h exp=%0h", k, {owner, reg_in}, {exp_o[k], (k == 0) ? 8'hA0 : 8'hA3});
            end
            @(negedge clk);
            @(negedge clk);
            req[exp_o[k]] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int first;
        wr_data = 32'h0000_6600;
        req     = 4'b0010;
        wait_grant(ok);
        first = cyc;
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack !== 4'b0010) begin
            failures++; $display("FAIL b2b_ack1 got=%b exp=0010", ack);
        end
        wait_grant(ok);
        checks++; if (!ok || owner !== 2'd1 || cyc - first !== 4) begin
            failures++; $display("FAIL b2b_regrant got=ok%0d/o%0d/d%0d exp=ok1/o1/d4", ok, owner, cyc - first);
        end
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic test_readback_error();
        bit ok;
        wr_data   = 32'h0000_3C5A;
        force_bad = 1'b1;
        req       = 4'b0001;
        wait_grant(ok);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({ack, err, err_sticky} !== {4'b0001, 1'b1, 1'b1}) begin
            failures++; $display("FAIL err_ack got=%0h exp=%0h", {ack, err, err_sticky}, {4'b0001, 1'b1, 1'b1});
        end
        req       = 4'b0000;
        @(negedge clk);
        force_bad = 1'b0;
        checks++; if ({err, err_sticky} !== 2'b01) begin
            failures++; $display("FAIL err_pulse_len got=%b exp=01", {err, err_sticky});
        end
        req = 4'b0010;
        wait_grant(ok);
        @(negedge clk);
        @(negedge clk);
        checks++; if ({ack, err, err_sticky} !== {4'b0010, 1'b0, 1'b1}) begin
            failures++; $display("FAIL err_sticky_hold got=%0h exp=%0h", {ack, err, err_sticky}, {4'b0010, 1'b0, 1'b1});
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw_ack;
        wr_data = 32'h00BB_0011;
        req     = 4'b0001;
        wait_grant(ok);
        @(negedge clk);
        #1 res = 1'b0;
        #1;
        checks++; if ({reg_en, reg_in, ack, err, err_sticky, owner, busy} !== 17'h0) begin
            failures++; $display("FAIL midreset_clear got=%0h exp=0", {reg_en, reg_in, ack, err, err_sticky, owner, busy});
        end
        req = 4'b0100;
        #1 res = 1'b1;
        saw_ack = 1'b0;
        @(negedge clk);
        if (ack !== 4'h0) saw_ack = 1'b1;
        checks++; if ({reg_en, owner, reg_in} !== {1'b1, 2'd2, 8'hBB}) begin
            failures++; $display("FAIL midreset_regrant got=%0h exp=%0h", {reg_en, owner, reg_in}, {1'b1, 2'd2, 8'hBB});
        end
        @(negedge clk);
        if (ack !== 4'h0) saw_ack = 1'b1;
        checks++; if (saw_ack) begin
            failures++; $display("FAIL midreset_no_ack got=ack exp=none");
        end
        @(negedge clk);
        checks++; if ({ack, err, err_sticky} !== {4'b0100, 1'b0, 1'b0}) begin
            failures++; $display("FAIL midreset_ack got=%0h exp=%0h", {ack, err, err_sticky}, {4'b0100, 1'b0, 1'b0});
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res       = 1'b0;
        req       = 4'b0000;
        wr_data   = 32'h0;
        force_bad = 1'b0;
        cyc       = 0;
        checks    = 0;
        failures  = 0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_back_to_back();
        test_readback_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
